i2s_stereo_transmitter: RTL and testbench

//  Consumes the stereo output of the mixer (left/right samples, valid/ready handshake).

---
 rtl/i2s_pkg.sv | 13 +
 rtl/i2s_bclk_gen.sv | 38 +++
 rtl/i2s_stereo_transmitter.sv | 144 ++++++++++++++
 tb/tb_i2s_stereo_transmitter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S stereo transmitter.
package i2s_pkg;

    typedef enum logic {
        DISABLED = 1'b0,
        RUN      = 1'b1
    } i2s_tx_state_t;

    // Word-select levels on i2s_lrclk
    localparam logic I2S_LEFT  = 1'b0;
    localparam logic I2S_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: i2s_bclk toggles every BCLK_DIV_P clk cycles while run is high.
// fall_event is high on the clk whose edge takes i2s_bclk from 1 to 0.
module i2s_bclk_gen #(
    parameter int BCLK_DIV_P = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic i2s_bclk,
    output logic fall_event
);

    localparam int CNT_W = (BCLK_DIV_P > 1) ? $clog2(BCLK_DIV_P) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BCLK_DIV_P - 1);

    logic [CNT_W-1:0] div_cnt;
    logic             wrap;

    assign wrap       = (div_cnt == CNT_LAST);
    assign fall_event = run && wrap && i2s_bclk;

    // Half-period counter; parked at zero with bclk low whenever the transmitter is idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            i2s_bclk <= 1'b0;
        end else if (!run) begin
            div_cnt  <= '0;
            i2s_bclk <= 1'b0;
        end else if (wrap) begin
            div_cnt  <= '0;
            i2s_bclk <= ~i2s_bclk;
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/i2s_stereo_transmitter.sv
// I2S master transmitter: one-pair skid buffer feeding a 2*SLOT frame shift register.
// Frames start at the bclk fall where the frame counter reaches 1, which yields the
// standard one-bit delay between the lrclk edge and the MSB of each slot.
module i2s_stereo_transmitter
    import i2s_pkg::*;
#(
    parameter int AUDIO_WIDTH_P = 24,
    parameter int SLOT_WIDTH_P  = 32,
    parameter int BCLK_DIV_P    = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic signed [AUDIO_WIDTH_P-1:0] ing_left,
    input  logic signed [AUDIO_WIDTH_P-1:0] ing_right,
    input  logic                            ing_valid,
    output logic                            ing_ready,
    output logic                            i2s_bclk,
    output logic                            i2s_lrclk,
    output logic                            i2s_sdata,
    input  logic                            cr_enable,
    input  logic                            cr_clear_underrun,
    output logic                            sr_tx_underrun
);

    localparam int FRAME_W = 2 * SLOT_WIDTH_P;
    localparam int K_W     = $clog2(FRAME_W);
    localparam int PAD_W   = SLOT_WIDTH_P - AUDIO_WIDTH_P;
    localparam logic [K_W-1:0] K_LAST  = K_W'(FRAME_W - 1);
    localparam logic [K_W-1:0] K_LOAD  = K_W'(1);
    localparam logic [K_W-1:0] K_RIGHT = K_W'(SLOT_WIDTH_P);

    i2s_tx_state_t state, state_next;

    logic [K_W-1:0]           k;
    logic [K_W-1:0]           k_new;
    logic [FRAME_W-1:0]       sr;
    logic [FRAME_W-1:0]       frame;
    logic [AUDIO_WIDTH_P-1:0] buf_left;
    logic [AUDIO_WIDTH_P-1:0] buf_right;
    logic                     buf_full;
    logic                     fall_event;
    logic                     load_point;
    logic                     accept;
    logic                     stop;
    logic                     underrun_set;

    i2s_bclk_gen #(
        .BCLK_DIV_P (BCLK_DIV_P)
    ) u_bclk_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (state == RUN),
        .i2s_bclk   (i2s_bclk),
        .fall_event (fall_event)
    );

    assign k_new        = (k == K_LAST) ? '0 : k + K_W'(1);
    assign load_point   = fall_event && (k_new == K_LOAD);
    assign ing_ready    = (state == RUN) && !buf_full;
    assign accept       = ing_valid && ing_ready;
    // Enable is only honoured at a frame boundary so the current frame always completes
    assign stop         = load_point && !cr_enable;
    assign underrun_set = load_point && cr_enable && !buf_full;

    // Frame image: each sample left-justified in its slot, padding bits zero; silence when empty
    always_comb begin
        frame = '0;
        if (buf_full) begin
            frame = (FRAME_W'(buf_left) << (FRAME_W - AUDIO_WIDTH_P))
                  | (FRAME_W'(buf_right) << PAD_W);
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            DISABLED: if (cr_enable) state_next = RUN;
            RUN:      if (stop) state_next = DISABLED;
            default:  state_next = DISABLED;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= DISABLED;
        else        state <= state_next;
    end

    // Skid buffer: a pair taken on an underrun load point survives into the next frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_full  <= 1'b0;
            buf_left  <= '0;
            buf_right <= '0;
        end else if (state == DISABLED || stop) begin
            buf_full <= 1'b0;
        end else if (accept) begin
            buf_full  <= 1'b1;
            buf_left  <= ing_left;
            buf_right <= ing_right;
        end else if (load_point) begin
            buf_full <= 1'b0;
        end
    end

    // Frame counter, word select and serialiser, all advanced on bclk falls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k         <= '0;
            sr        <= '0;
            i2s_lrclk <= 1'b0;
            i2s_sdata <= 1'b0;
        end else if (state == DISABLED) begin
            // Parking k at the last count makes the first fall after enable land on k = 0
            k         <= K_LAST;
            sr        <= '0;
            i2s_lrclk <= 1'b0;
            i2s_sdata <= 1'b0;
        end else if (stop) begin
            sr        <= '0;
            i2s_lrclk <= 1'b0;
            i2s_sdata <= 1'b0;
        end else if (fall_event) begin
            k         <= k_new;
            i2s_lrclk <= (k_new >= K_RIGHT) ? I2S_RIGHT : I2S_LEFT;
            if (load_point) begin
                i2s_sdata <= frame[FRAME_W-1];
                sr        <= frame << 1;
            end else begin
                i2s_sdata <= sr[FRAME_W-1];
                sr        <= sr << 1;
            end
        end
    end

    // Sticky underrun flag; a new underrun outranks a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 sr_tx_underrun <= 1'b0;
        else if (underrun_set)      sr_tx_underrun <= 1'b1;
        else if (cr_clear_underrun) sr_tx_underrun <= 1'b0;
    end

endmodule

// File: tb/tb_i2s_stereo_transmitter.sv
// Bench for i2s_stereo_transmitter (AW=24, S=32, DIV=2). Expected outputs come from a
// timing model: fall n happens n*4 clks after enable, frame m loads at fall 2+64m, and
// each frame carries the oldest pair accepted before its load, or silence.
module tb_i2s_stereo_transmitter;

    localparam int AW        = 24;
    localparam int S         = 32;
    localparam int DIV       = 2;
    localparam int FW        = 2 * S;
    localparam int BCLK_CLK  = 2 * DIV;
    localparam int FRAME_CLK = FW * BCLK_CLK;
    localparam int LOAD0     = 2 * BCLK_CLK;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] ing_left;
    logic [AW-1:0] ing_right;
    logic          ing_valid;
    logic          ing_ready;
    logic          i2s_bclk;
    logic          i2s_lrclk;
    logic          i2s_sdata;
    logic          cr_enable;
    logic          cr_clear_underrun;
    logic          sr_tx_underrun;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          m_en     = 0;
    bit          m_running;
    bit          m_und;
    bit          cap_en;
    logic [63:0] cap;
    logic [47:0] m_pend[$];
    logic [47:0] src_q[$];
    logic [63:0] m_frames[$];

    i2s_stereo_transmitter #(
        .AUDIO_WIDTH_P (AW),
        .SLOT_WIDTH_P  (S),
        .BCLK_DIV_P    (DIV)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ing_left          (ing_left),
        .ing_right         (ing_right),
        .ing_valid         (ing_valid),
        .ing_ready         (ing_ready),
        .i2s_bclk          (i2s_bclk),
        .i2s_lrclk         (i2s_lrclk),
        .i2s_sdata         (i2s_sdata),
        .cr_enable         (cr_enable),
        .cr_clear_underrun (cr_clear_underrun),
        .sr_tx_underrun    (sr_tx_underrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [47:0] rand_pair();
        logic [47:0] p;
        p[47:24] = 24'($urandom);
        p[23:0]  = 24'($urandom);
        return p;
    endfunction

    task automatic model_reset();
        m_running = 1'b0;
        m_und     = 1'b0;
        m_pend.delete();
        m_frames.delete();
    endtask

    task automatic src_drive();
        if (src_q.size() > 0) begin
            ing_valid = 1'b1;
            ing_left  = src_q[0][47:24];
            ing_right = src_q[0][23:0];
        end else begin
            ing_valid = 1'b0;
        end
    endtask

    // One clk: update the model for the coming edge, then compare every output 1 time unit after it
    task automatic step();
        bit          acc;
        bit          hs;
        bit          set;
        int          t;
        int          n;
        int          k;
        int          m;
        int          bi;
        logic        eb;
        logic        el;
        logic        ed;
        logic [47:0] pr;
        acc = ing_valid && m_running && (m_pend.size() == 0);
        hs  = acc;
        set = 1'b0;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            model_reset();
        end else if (m_running) begin
            t = cyc - m_en;
            if (t >= LOAD0 && (t - LOAD0) % FRAME_CLK == 0) begin
                if (!cr_enable) begin
                    m_running = 1'b0;
                    m_pend.delete();
                    acc = 1'b0;
                end else if (m_pend.size() > 0) begin
                    pr = m_pend.pop_front();
                    m_frames.push_back({pr[47:24], 8'h00, pr[23:0], 8'h00});
                end else begin
                    m_frames.push_back(64'h0);
                    set = 1'b1;
                end
            end
            if (acc) m_pend.push_back({ing_left, ing_right});
        end else if (cr_enable) begin
            m_running = 1'b1;
            m_en      = cyc;
            m_pend.delete();
            m_frames.delete();
        end
        if (rst_n) begin
            if (set)                    m_und = 1'b1;
            else if (cr_clear_underrun) m_und = 1'b0;
        end
        #1;
        if (hs && src_q.size() > 0) void'(src_q.pop_front());
        src_drive();
        eb = 1'b0;
        el = 1'b0;
        ed = 1'b0;
        if (m_running) begin
            t  = cyc - m_en;
            n  = t / BCLK_CLK;
            eb = ((t % BCLK_CLK) >= DIV);
            if (n >= 1) begin
                k  = (n - 1) % FW;
                el = (k >= S);
                if (n >= 2) begin
                    if (k == 0) begin
                        m  = (n - 1) / FW - 1;
                        bi = 0;
                    end else begin
                        m  = (n - 2) / FW;
                        bi = FW - k;
                    end
                    if (m < m_frames.size()) ed = m_frames[m][bi];
                    if (cap_en && m == 0 && (t % BCLK_CLK) == 0) cap[bi] = i2s_sdata;
                end
            end
        end
        check("bclk", i2s_bclk, eb);
        check("lrclk", i2s_lrclk, el);
        check("sdata", i2s_sdata, ed);
        check("ready", ing_ready, m_running && (m_pend.size() == 0));
        check("underrun", sr_tx_underrun, m_und);
    endtask

    task automatic run_until(input int target);
        while ((cyc - m_en) < target) step();
    endtask

    initial begin
        rst_n             = 1'b0;
        cr_enable         = 1'b0;
        cr_clear_underrun = 1'b0;
        ing_valid         = 1'b0;
        ing_left          = '0;
        ing_right         = '0;
        cap_en            = 1'b0;
        cap               = '0;
        model_reset();
        repeat (3) step();
        rst_n = 1'b1;
        repeat (4) step();

        // Extreme samples first, then two random pairs, valid held high from before enable
        cap_en = 1'b1;
        src_q.push_back({24'h7FFFFF, 24'h800001});
        repeat (2) src_q.push_back(rand_pair());
        src_drive();
        cr_enable = 1'b1;
        step();
        run_until(LOAD0 + FRAME_CLK + BCLK_CLK);
        cap_en = 1'b0;
        check("left_slot", cap[63:32], 64'h7FFFFF00);
        check("right_slot", cap[31:0], 64'h80000100);

        // Starved frame 3, then clear the sticky flag and refill
        run_until(LOAD0 + 3 * FRAME_CLK + 100);
        check("underrun_held", sr_tx_underrun, 1'b1);
        cr_clear_underrun = 1'b1;
        step();
        cr_clear_underrun = 1'b0;
        check("underrun_cleared", sr_tx_underrun, 1'b0);
        src_q.push_back(rand_pair());
        src_drive();

        // Pair first offered exactly on an empty-buffer load point
        run_until(LOAD0 + 5 * FRAME_CLK - 1);
        src_q.push_back(rand_pair());
        src_drive();

        // Buffer a pair, then drop enable mid-frame at k = 40
        run_until(LOAD0 + 6 * FRAME_CLK + 16);
        src_q.push_back(rand_pair());
        src_drive();
        run_until(LOAD0 + 6 * FRAME_CLK + 39 * BCLK_CLK);
        cr_enable = 1'b0;
        run_until(LOAD0 + 7 * FRAME_CLK + 64);

        // Re-enable, then reset asynchronously at k = 20 while bclk is high
        src_q.push_back(rand_pair());
        src_drive();
        cr_enable = 1'b1;
        step();
        run_until(LOAD0 + 19 * BCLK_CLK + DIV);
        #2;
        rst_n = 1'b0;
        model_reset();
        src_q.delete();
        #1;
        check("rst_bclk", i2s_bclk, 1'b0);
        check("rst_lrclk", i2s_lrclk, 1'b0);
        check("rst_sdata", i2s_sdata, 1'b0);
        check("rst_ready", ing_ready, 1'b0);
        cr_enable = 1'b0;
        src_drive();
        repeat (3) step();
        rst_n = 1'b1;
        repeat (20) step();

        // Recovery after reset
        src_q.push_back(rand_pair());
        src_drive();
        cr_enable = 1'b1;
        step();
        run_until(LOAD0 + FRAME_CLK + 2 * BCLK_CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
